// File: rtl/tone_pkg.sv
// Shared types and limits for the square-wave tone synthesiser.
package tone_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_PLAY = 1'b1
  } ch_state_e;

  localparam int MAX_CH = 8;

endpackage

// File: rtl/tone_channel.sv
// One tone channel: holds a latched half-period, a phase counter and the
// remaining half-period count, and produces the square wave, busy and the
// end-of-note pulse.
module tone_channel
  import tone_pkg::*;
#(
  parameter int WIDTH_DIV = 10,
  parameter int WIDTH_DUR = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WIDTH_DIV-1:0] load_div,
  input  logic [WIDTH_DUR-1:0] load_dur,
  output logic                 tone,
  output logic                 busy,
  output logic                 done
);

  ch_state_e            state, state_n;
  logic [WIDTH_DIV-1:0] div_q, div_n;
  logic [WIDTH_DIV-1:0] count, count_n;
  logic [WIDTH_DUR-1:0] rem, rem_n;
  logic                 tone_n, busy_n, done_n;
  logic                 toggle;

  // A phase ends when the counter has reached the latched half-period.
  assign toggle = (count == div_q);

  // Next-state and next-output decode; a command always overrides the tick.
  always_comb begin
    state_n = state;
    div_n   = div_q;
    count_n = count;
    rem_n   = rem;
    tone_n  = tone;
    busy_n  = busy;
    done_n  = 1'b0;
    if (load) begin
      if (load_div != '0) begin
        state_n = CH_PLAY;
        div_n   = load_div;
        count_n = WIDTH_DIV'(1);
        rem_n   = load_dur;
        tone_n  = 1'b0;
        busy_n  = 1'b1;
      end else begin
        // Stop: silent abort, no done pulse.
        state_n = CH_IDLE;
        tone_n  = 1'b0;
        busy_n  = 1'b0;
      end
    end else if (state == CH_PLAY) begin
      if (toggle) begin
        count_n = WIDTH_DIV'(1);
        if (rem == WIDTH_DUR'(1)) begin
          // Last half-period elapsed: force the line low and flag the end.
          state_n = CH_IDLE;
          tone_n  = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          tone_n = ~tone;
          // rem==0 means endless; it stays parked at zero.
          if (rem != '0) begin
            rem_n = rem - WIDTH_DUR'(1);
          end
        end
      end else begin
        count_n = count + WIDTH_DIV'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CH_IDLE;
      div_q <= '0;
      count <= '0;
      rem   <= '0;
      tone  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      div_q <= div_n;
      count <= count_n;
      rem   <= rem_n;
      tone  <= tone_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule

// File: rtl/tone_synth.sv
// Multi-channel square-wave tone synthesiser: command ready decode and
// demux to the channels, plus a registered count of high tone lines for
// the downstream DAC.
module tone_synth
  import tone_pkg::*;
#(
  parameter  int N_CH      = 3,
  parameter  int WIDTH_DIV = 10,
  parameter  int WIDTH_DUR = 16,
  localparam int CHW       = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int MIXW      = $clog2(N_CH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CHW-1:0]       cmd_ch,
  input  logic [WIDTH_DIV-1:0] cmd_div,
  input  logic [WIDTH_DUR-1:0] cmd_dur,
  output logic [N_CH-1:0]      tone,
  output logic [N_CH-1:0]      busy,
  output logic [N_CH-1:0]      done,
  output logic [MIXW-1:0]      mix
);

  if (N_CH < 1 || N_CH > MAX_CH) begin : g_bad_nch
    $error("tone_synth: N_CH out of range");
  end

  logic            ch_ok;
  logic            busy_sel;
  logic [N_CH-1:0] load;

  function automatic logic [MIXW-1:0] popcount(input logic [N_CH-1:0] v);
    logic [MIXW-1:0] c;
    c = '0;
    for (int i = 0; i < N_CH; i++) begin
      c = c + MIXW'(v[i]);
    end
    return c;
  endfunction

  // Commands to a non-existent channel are swallowed rather than stalled.
  assign ch_ok = (32'(cmd_ch) < N_CH);

  // Busy flag of the addressed channel, safe for out-of-range indices.
  always_comb begin
    busy_sel = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (cmd_ch == CHW'(i)) begin
        busy_sel = busy[i];
      end
    end
  end

  // Stops are always taken; new notes wait for the channel to go idle.
  assign cmd_ready = !ch_ok || (cmd_div == '0) || !busy_sel;

  // Route an accepted command to exactly one channel.
  always_comb begin
    load = '0;
    for (int i = 0; i < N_CH; i++) begin
      load[i] = cmd_valid && cmd_ready && ch_ok && (cmd_ch == CHW'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    tone_channel #(
      .WIDTH_DIV(WIDTH_DIV),
      .WIDTH_DUR(WIDTH_DUR)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .load    (load[g]),
      .load_div(cmd_div),
      .load_dur(cmd_dur),
      .tone    (tone[g]),
      .busy    (busy[g]),
      .done    (done[g])
    );
  end

  // Mix level trails the tone vector by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      mix <= '0;
    end else begin
      mix <= popcount(tone);
    end
  end

endmodule

// File: tb/tb_tone_synth.sv
// Bench for tone_synth: directed note commands, a closed-form note model
// compared every cycle, and hand-computed spot checks.
module tb_tone_synth;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_ch;
  logic [9:0]  cmd_div;
  logic [15:0] cmd_dur;
  logic [2:0]  tone, busy, done;
  logic [1:0]  mix;

  tone_synth #(.N_CH(3), .WIDTH_DIV(10), .WIDTH_DUR(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_div(cmd_div), .cmd_dur(cmd_dur),
    .tone(tone), .busy(busy), .done(done), .mix(mix)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Note model: each channel remembers when its note started and derives
  // its outputs from elapsed cycles.
  bit         m_act [3];
  int         m_start [3];
  int         m_div [3];
  int         m_dur [3];
  logic [2:0] e_tone = '0, e_busy = '0, e_done = '0;
  logic [1:0] e_mix = '0;
  bit         live = 1'b0;
  int         cyc = 0;

  function automatic bit m_ready(input logic [1:0] ch, input logic [9:0] dv);
    if (ch >= 2'd3) return 1'b1;
    if (dv == '0) return 1'b1;
    return !e_busy[ch];
  endfunction

  always @(posedge clk) begin : model
    bit acc;
    int k, p;
    cyc++;
    if (rst) begin
      for (int c = 0; c < 3; c++) m_act[c] = 1'b0;
      e_tone = '0; e_busy = '0; e_done = '0; e_mix = '0;
      live = 1'b1;
    end else if (live) begin
      acc = cmd_valid && m_ready(cmd_ch, cmd_div) && (cmd_ch < 2'd3);
      e_mix = 2'($countones(e_tone));
      if (acc) begin
        if (cmd_div == '0) begin
          m_act[cmd_ch] = 1'b0;
        end else begin
          m_act[cmd_ch]   = 1'b1;
          m_start[cmd_ch] = cyc;
          m_div[cmd_ch]   = int'(cmd_div);
          m_dur[cmd_ch]   = int'(cmd_dur);
        end
      end
      for (int c = 0; c < 3; c++) begin
        if (m_act[c]) begin
          k = cyc - m_start[c];
          p = k / m_div[c];
          if (m_dur[c] != 0 && p >= m_dur[c]) begin
            m_act[c]  = 1'b0;
            e_tone[c] = 1'b0;
            e_busy[c] = 1'b0;
            e_done[c] = (k == m_dur[c] * m_div[c]);
          end else begin
            e_tone[c] = (p % 2) == 1;
            e_busy[c] = 1'b1;
            e_done[c] = 1'b0;
          end
        end else begin
          e_tone[c] = 1'b0;
          e_busy[c] = 1'b0;
          e_done[c] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("tone",  32'(tone),      32'(e_tone));
      check("busy",  32'(busy),      32'(e_busy));
      check("done",  32'(done),      32'(e_done));
      check("mix",   32'(mix),       32'(e_mix));
      check("ready", 32'(cmd_ready), 32'(m_ready(cmd_ch, cmd_div)));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] ch, input logic [9:0] dv, input logic [15:0] du);
    cmd_valid = 1'b1; cmd_ch = ch; cmd_div = dv; cmd_dur = du;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Sample one channel for n cycles starting at the cycle after the last edge.
  task automatic watch(input int n, input int ch, output logic [63:0] tv,
                       output int bcnt, output int dcnt, output int rise, output int dk);
    tv = '0; bcnt = 0; dcnt = 0; rise = -1; dk = -1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      tv[k] = tone[ch];
      if (busy[ch]) bcnt++;
      if (done[ch]) begin dcnt++; dk = k; end
      if (tone[ch] && rise < 0) rise = k;
    end
    @(posedge clk);
    #1;
  endtask

  logic [63:0] tv;
  int bc, dc, fr, dk, mx;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_ch = '0; cmd_div = '0; cmd_dur = '0;
    idle(3);
    @(negedge clk);
    check("rst_state", {26'd0, tone, busy}, 32'd0);
    check("rst_mix",   32'(mix), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // div=3 dur=4
    issue(2'd0, 10'd3, 16'd4);
    watch(16, 0, tv, bc, dc, fr, dk);
    check("t1_rise",    32'(fr), 32'd3);
    check("t1_busy",    32'(bc), 32'd12);
    check("t1_donecnt", 32'(dc), 32'd1);
    check("t1_doneat",  32'(dk), 32'd12);
    check("t1_pattern", 32'(tv[15:0]), 32'h0E38);

    // div=1 dur=3 (odd: last toggle suppressed)
    issue(2'd1, 10'd1, 16'd3);
    watch(6, 1, tv, bc, dc, fr, dk);
    check("t2_pattern", 32'(tv[5:0]), 32'h02);
    check("t2_busy",    32'(bc), 32'd3);
    check("t2_donecnt", 32'(dc), 32'd1);
    check("t2_doneat",  32'(dk), 32'd3);

    // endless note, blocked re-command, then stop
    issue(2'd0, 10'd5, 16'd0);
    idle(7);
    cmd_valid = 1'b1; cmd_ch = 2'd0; cmd_div = 10'd2; cmd_dur = 16'd0;
    @(negedge clk);
    check("t3_ready_blocked", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    cmd_div = 10'd0;
    @(negedge clk);
    check("t3_ready_stop", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    watch(8, 0, tv, bc, dc, fr, dk);
    check("t3_busy",  32'(bc), 32'd0);
    check("t3_done",  32'(dc), 32'd0);
    check("t3_tone",  32'(tv[7:0]), 32'd0);

    // three channels staggered by one cycle
    issue(2'd0, 10'd2, 16'd0);
    issue(2'd1, 10'd2, 16'd0);
    issue(2'd2, 10'd2, 16'd0);
    mx = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (int'(mix) > mx) mx = int'(mix);
    end
    @(posedge clk); #1;
    check("t4_mix_max", 32'(mx), 32'd2);
    issue(2'd0, 10'd0, 16'd0);
    issue(2'd1, 10'd0, 16'd0);
    issue(2'd2, 10'd0, 16'd0);
    idle(2);

    // out-of-range channel
    cmd_valid = 1'b1; cmd_ch = 2'd3; cmd_div = 10'd2; cmd_dur = 16'd5;
    @(negedge clk);
    check("t5_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    idle(2);
    @(negedge clk);
    check("t5_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // reset mid-note, then immediate new command
    issue(2'd2, 10'd4, 16'd10);
    idle(6);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_after_rst", {23'd0, tone, busy, done}, 32'd0);
    check("t6_mix", 32'(mix), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cmd_valid = 1'b1; cmd_ch = 2'd2; cmd_div = 10'd4; cmd_dur = 16'd10;
    @(negedge clk);
    check("t6_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    watch(45, 2, tv, bc, dc, fr, dk);
    check("t6_busy",    32'(bc), 32'd40);
    check("t6_donecnt", 32'(dc), 32'd1);
    check("t6_doneat",  32'(dk), 32'd40);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
